mmio_io_unit: RTL and testbench

//  Memory-mapped I/O slave fed by the MEM stage. It decodes the MEM-stage address and services
//  HEX, LEDR, KEY, SW and a free-running timer. Reads return combinationally, so the MEM latch

---
 rtl/mmio_io_unit.sv | 153 +++++++++++++++
 tb/tb_mmio_io_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_unit.sv
// mmio_io_unit: MEM-stage memory-mapped I/O slave for HEX, LEDR, KEY, SW and a timer.
// Reads are combinational so the MEM latch captures them alongside D-MEM data.
module mmio_io_unit #(
    parameter int unsigned      DBITS      = 32,
    parameter logic [31:0]      TICKCYCLES = 32'd50000,
    parameter logic [DBITS-1:0] ADDRHEX    = 32'hFFFFF000,
    parameter logic [DBITS-1:0] ADDRLEDR   = 32'hFFFFF020,
    parameter logic [DBITS-1:0] ADDRKEY    = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL  = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSW     = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL  = 32'hFFFFF094,
    parameter logic [DBITS-1:0] ADDRTCNT   = 32'hFFFFF100,
    parameter logic [DBITS-1:0] ADDRTLIM   = 32'hFFFFF104,
    parameter logic [DBITS-1:0] ADDRTCTRL  = 32'hFFFFF108
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [23:0]      HEX_out,
    output logic [9:0]       LEDR_out
);

    logic hit_hex, hit_ledr, hit_key, hit_kctrl, hit_sw;
    logic hit_sctrl, hit_tcnt, hit_tlim, hit_tctrl;

    assign hit_hex   = (addr == ADDRHEX);
    assign hit_ledr  = (addr == ADDRLEDR);
    assign hit_key   = (addr == ADDRKEY);
    assign hit_kctrl = (addr == ADDRKCTRL);
    assign hit_sw    = (addr == ADDRSW);
    assign hit_sctrl = (addr == ADDRSCTRL);
    assign hit_tcnt  = (addr == ADDRTCNT);
    assign hit_tlim  = (addr == ADDRTLIM);
    assign hit_tctrl = (addr == ADDRTCTRL);

    assign sel = hit_hex | hit_ledr | hit_key | hit_kctrl | hit_sw
               | hit_sctrl | hit_tcnt | hit_tlim | hit_tctrl;

    logic [23:0]      hex_q, hex_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [3:0]       key_s1_q, key_s2_q, key_prv_q;
    logic [9:0]       sw_s1_q, sw_s2_q, sw_prv_q;
    logic [3:0]       kstk_q, kstk_d;
    logic [9:0]       sstk_q, sstk_d;
    logic [DBITS-1:0] tcnt_q, tcnt_d;
    logic [DBITS-1:0] tlim_q, tlim_d;
    logic [31:0]      presc_q, presc_d;
    logic             rdy_q, rdy_d;
    logic             ovr_q, ovr_d;

    logic       tick, wrap, rset, oset;
    logic [3:0] kclr;
    logic [9:0] sclr;
    logic [1:0] tclr;

    assign tick = (presc_q == TICKCYCLES - 32'd1);
    assign wrap = (tlim_q != '0) && (tcnt_q == tlim_q - DBITS'(1));

    always_comb begin
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        tlim_d  = tlim_q;
        tcnt_d  = tcnt_q;
        presc_d = tick ? 32'd0 : presc_q + 32'd1;
        rset    = 1'b0;
        oset    = 1'b0;
        kclr    = (we && hit_kctrl) ? wdata[3:0] : 4'd0;
        sclr    = (we && hit_sctrl) ? wdata[9:0] : 10'd0;
        tclr    = (we && hit_tctrl) ? wdata[1:0] : 2'd0;
        if (we && hit_hex)  hex_d  = wdata[23:0];
        if (we && hit_ledr) ledr_d = wdata[9:0];
        if (we && hit_tlim) tlim_d = wdata;
        // a TCNT store restarts the tick period and suppresses a coincident tick
        if (we && hit_tcnt) begin
            tcnt_d  = wdata;
            presc_d = 32'd0;
        end else if (tick) begin
            if (wrap) begin
                tcnt_d = '0;
                rset   = 1'b1;
                oset   = rdy_q;
            end else begin
                tcnt_d = tcnt_q + DBITS'(1);
            end
        end
        kstk_d = (kstk_q & ~kclr) | (key_s2_q & ~key_prv_q);
        sstk_d = (sstk_q & ~sclr) | (sw_s2_q ^ sw_prv_q);
        rdy_d  = (rdy_q & ~tclr[0]) | rset;
        ovr_d  = (ovr_q & ~tclr[1]) | oset;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hex_q     <= 24'hFEDEAD;
            ledr_q    <= '0;
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_prv_q <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prv_q  <= '0;
            kstk_q    <= '0;
            sstk_q    <= '0;
            tcnt_q    <= '0;
            tlim_q    <= '0;
            presc_q   <= '0;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            hex_q     <= hex_d;
            ledr_q    <= ledr_d;
            key_s1_q  <= ~KEY;
            key_s2_q  <= key_s1_q;
            key_prv_q <= key_s2_q;
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            sw_prv_q  <= sw_s2_q;
            kstk_q    <= kstk_d;
            sstk_q    <= sstk_d;
            tcnt_q    <= tcnt_d;
            tlim_q    <= tlim_d;
            presc_q   <= presc_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_hex:   rdata = DBITS'(hex_q);
            hit_ledr:  rdata = DBITS'(ledr_q);
            hit_key:   rdata = DBITS'(key_s2_q);
            hit_kctrl: rdata = DBITS'(kstk_q);
            hit_sw:    rdata = DBITS'(sw_s2_q);
            hit_sctrl: rdata = DBITS'(sstk_q);
            hit_tcnt:  rdata = tcnt_q;
            hit_tlim:  rdata = tlim_q;
            hit_tctrl: rdata = DBITS'({ovr_q, rdy_q});
            default:   rdata = '0;
        endcase
    end

    assign HEX_out  = hex_q;
    assign LEDR_out = ledr_q;

endmodule

// File: tb/tb_mmio_io_unit.sv
// tb_mmio_io_unit: directed and randomised checks of mmio_io_unit
// against a cycle-level reference model of the register map.
module tb_mmio_io_unit;
    localparam int T = 4;
    localparam logic [31:0] A_HEX   = 32'hFFFFF000;
    localparam logic [31:0] A_LEDR  = 32'hFFFFF020;
    localparam logic [31:0] A_KEY   = 32'hFFFFF080;
    localparam logic [31:0] A_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] A_SW    = 32'hFFFFF090;
    localparam logic [31:0] A_SCTRL = 32'hFFFFF094;
    localparam logic [31:0] A_TCNT  = 32'hFFFFF100;
    localparam logic [31:0] A_TLIM  = 32'hFFFFF104;
    localparam logic [31:0] A_TCTRL = 32'hFFFFF108;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic [31:0] addr, wdata, rdata;
    logic        we, sel;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [23:0] HEX_out;
    logic [9:0]  LEDR_out;

    always #5 clk = ~clk;

    mmio_io_unit #(.TICKCYCLES(32'd4)) dut (
        .clk(clk), .RESET_N(RESET_N), .addr(addr), .wdata(wdata),
        .we(we), .rdata(rdata), .sel(sel), .KEY(KEY), .SW(SW),
        .HEX_out(HEX_out), .LEDR_out(LEDR_out)
    );

    int ncmp = 0;
    int nfail = 0;

    // reference model; kh/sh hold pin samples from the last three edges
    logic [23:0] m_hex;
    logic [9:0]  m_ledr;
    logic [3:0]  kh [3];
    logic [9:0]  sh [3];
    logic [3:0]  m_kst;
    logic [9:0]  m_sst;
    logic [31:0] m_tcnt, m_tlim;
    int          m_phase;
    bit          m_rdy, m_ovr;
    logic [31:0] amap [11];

    task automatic model_reset();
        m_hex = 24'hFEDEAD;
        m_ledr = '0;
        for (int i = 0; i < 3; i++) begin
            kh[i] = '0;
            sh[i] = '0;
        end
        m_kst = '0;
        m_sst = '0;
        m_tcnt = '0;
        m_tlim = '0;
        m_phase = 0;
        m_rdy = 0;
        m_ovr = 0;
    endtask

    function automatic logic [31:0] model_read(logic [31:0] a);
        case (a)
            A_HEX:   return {8'h0, m_hex};
            A_LEDR:  return {22'h0, m_ledr};
            A_KEY:   return {28'h0, kh[1]};
            A_KCTRL: return {28'h0, m_kst};
            A_SW:    return {22'h0, sh[1]};
            A_SCTRL: return {22'h0, m_sst};
            A_TCNT:  return m_tcnt;
            A_TLIM:  return m_tlim;
            A_TCTRL: return {30'h0, m_ovr, m_rdy};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_sel(logic [31:0] a);
        for (int i = 0; i < 9; i++)
            if (amap[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // advance the model by one clock edge with the inputs now applied
    task automatic model_edge();
        bit tick, rs, os;
        logic [3:0] kset;
        logic [9:0] sset;
        tick = (m_phase == T - 1);
        rs = 0;
        os = 0;
        kset = kh[1] & ~kh[2];
        sset = sh[1] ^ sh[2];
        if (we && addr == A_TCNT) begin
            m_tcnt = wdata;
            m_phase = 0;
        end else begin
            if (tick) begin
                if (m_tlim != 0 && m_tcnt + 1 == m_tlim) begin
                    m_tcnt = 0;
                    rs = 1;
                    os = m_rdy;
                end else begin
                    m_tcnt = m_tcnt + 1;
                end
            end
            m_phase = (m_phase + 1) % T;
        end
        if (we) begin
            case (addr)
                A_HEX:   m_hex = wdata[23:0];
                A_LEDR:  m_ledr = wdata[9:0];
                A_TLIM:  m_tlim = wdata;
                A_KCTRL: m_kst = m_kst & ~wdata[3:0];
                A_SCTRL: m_sst = m_sst & ~wdata[9:0];
                A_TCTRL: begin
                    if (wdata[0]) m_rdy = 0;
                    if (wdata[1]) m_ovr = 0;
                end
                default: ;
            endcase
        end
        m_kst = m_kst | kset;
        m_sst = m_sst | sset;
        if (rs) m_rdy = 1;
        if (os) m_ovr = 1;
        kh[2] = kh[1];
        kh[1] = kh[0];
        kh[0] = ~KEY;
        sh[2] = sh[1];
        sh[1] = sh[0];
        sh[0] = SW;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd(string tag, logic [31:0] a, logic [31:0] exp);
        addr = a;
        we = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        amap = '{A_HEX, A_LEDR, A_KEY, A_KCTRL, A_SW, A_SCTRL,
                 A_TCNT, A_TLIM, A_TCTRL, 32'hFFFFF004, 32'h0};
        RESET_N = 1'b0;
        addr = 32'h1000;
        wdata = '0;
        we = 1'b0;
        KEY = 4'hF;
        SW = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        RESET_N = 1'b1;

        // reset state
        check("rst_hex", {8'h0, HEX_out}, 32'h00FEDEAD);
        check("rst_ledr", {22'h0, LEDR_out}, 32'h0);
        rd("rst_unmapped", 32'h1000, 32'h0);
        check("rst_sel", {31'h0, sel}, 32'h0);

        // plain writes and a write to a read-only word
        wr(A_LEDR, 32'h3FF);
        check("ledr_wr", {22'h0, LEDR_out}, 32'h3FF);
        wr(A_HEX, 32'h12345678);
        check("hex_wr", {8'h0, HEX_out}, 32'h00345678);
        wr(A_KEY, 32'hF);
        rd("key_ro", A_KEY, 32'h0);
        check("key_sel", {31'h0, sel}, 32'h1);

        // key press, sticky bit, W1C
        KEY = 4'b1110;
        idle(1);
        rd("key_1edge", A_KEY, 32'h0);
        idle(1);
        rd("key_2edge", A_KEY, 32'h1);
        idle(1);
        rd("kctrl_set", A_KCTRL, 32'h1);
        idle(2);
        KEY = 4'hF;
        idle(3);
        rd("key_rel", A_KEY, 32'h0);
        rd("kctrl_hold", A_KCTRL, 32'h1);
        wr(A_KCTRL, 32'h1);
        rd("kctrl_clr", A_KCTRL, 32'h0);
        KEY = 4'b1110;
        idle(2);
        rd("kctrl_pre", A_KCTRL, 32'h0);
        wr(A_KCTRL, 32'h1);
        rd("kctrl_setwins", A_KCTRL, 32'h1);
        KEY = 4'hF;
        idle(3);
        wr(A_KCTRL, 32'hF);
        rd("kctrl_clr2", A_KCTRL, 32'h0);

        // switch change
        SW = 10'h200;
        idle(2);
        rd("sctrl_pre", A_SCTRL, 32'h0);
        idle(1);
        rd("sctrl_set", A_SCTRL, 32'h200);
        rd("sw_val", A_SW, 32'h200);
        wr(A_SCTRL, 32'h200);
        rd("sctrl_clr", A_SCTRL, 32'h0);

        // timer with limit 3
        wr(A_TLIM, 32'd3);
        wr(A_TCNT, 32'd0);
        idle(11);
        rd("tctrl_pre", A_TCTRL, 32'h0);
        rd("tcnt_pre", A_TCNT, 32'd2);
        idle(1);
        rd("tctrl_ready", A_TCTRL, 32'h1);
        rd("tcnt_wrap", A_TCNT, 32'd0);
        idle(11);
        rd("tctrl_noovr", A_TCTRL, 32'h1);
        idle(1);
        rd("tctrl_ovr", A_TCTRL, 32'h3);
        wr(A_TCTRL, 32'h3);
        rd("tctrl_clr", A_TCTRL, 32'h0);

        // free-run wrap at 2^32
        wr(A_TLIM, 32'd0);
        wr(A_TCNT, 32'hFFFFFFFF);
        idle(3);
        rd("tcnt_max", A_TCNT, 32'hFFFFFFFF);
        idle(1);
        rd("tcnt_roll", A_TCNT, 32'h0);
        rd("tctrl_free", A_TCTRL, 32'h0);

        // asynchronous reset mid-count
        wr(A_LEDR, 32'h155);
        idle(5);
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("arst_hex", {8'h0, HEX_out}, 32'h00FEDEAD);
        check("arst_ledr", {22'h0, LEDR_out}, 32'h0);
        rd("arst_tcnt", A_TCNT, 32'h0);
        rd("arst_sctrl", A_SCTRL, 32'h0);
        @(posedge clk);
        #1;
        RESET_N = 1'b1;

        // randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            int k;
            k = $urandom_range(0, 10);
            a = (k == 10) ? $urandom : amap[k];
            d = $urandom;
            if (a == A_TLIM) d = $urandom_range(0, 6);
            if (a == A_TCNT) d = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) KEY = 4'($urandom);
            if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
            addr = a;
            wdata = d;
            we = 1'($urandom_range(0, 1));
            #1;
            check("rnd_rdata", rdata, model_read(a));
            check("rnd_sel", {31'h0, sel}, {31'h0, model_sel(a)});
            step();
            we = 1'b0;
            check("rnd_hex", {8'h0, HEX_out}, {8'h0, m_hex});
            check("rnd_ledr", {22'h0, LEDR_out}, {22'h0, m_ledr});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
